// File: rtl/freq_meter_pkg.sv
// Shared state encoding and default parameter values for the reciprocal
// frequency meter and its TDC pulse sequencer.
package freq_meter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_OPEN    = 3'd2,
    ST_REPORT  = 3'd3,
    ST_HOLDOFF = 3'd4
  } state_e;

  localparam int DEF_CNT_W       = 32;
  localparam int DEF_PULSE_LEN   = 5;
  localparam int DEF_TIMEOUT_CYC = 1_000_000;
  localparam int DEF_HOLDOFF_CYC = 50_000;

endpackage

// File: rtl/tdc_pulse_seq.sv
// Emits a start_ext pulse then a stop_ext pulse, PULSE_LEN cycles each, per
// trigger; one trigger arriving mid-sequence is queued and replayed afterwards.
module tdc_pulse_seq
  import freq_meter_pkg::*;
#(
  parameter int PULSE_LEN = DEF_PULSE_LEN
) (
  input  logic clk_ref,
  input  logic sys_rstn,
  input  logic trig,
  input  logic abort,
  output logic start_ext,
  output logic stop_ext,
  output logic idle
);

  localparam int PW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
  localparam logic [PW-1:0] CNT_LAST = PW'(PULSE_LEN - 1);
  localparam logic [PW-1:0] CNT_ONE  = PW'(1);

  logic          start_r;
  logic          stop_r;
  logic          pend_r;
  logic [PW-1:0] cnt_r;

  // Start phase, then stop phase; a queued trigger restarts right after stop ends.
  always_ff @(posedge clk_ref) begin
    if (!sys_rstn || abort) begin
      start_r <= 1'b0;
      stop_r  <= 1'b0;
      pend_r  <= 1'b0;
      cnt_r   <= '0;
    end else if (start_r) begin
      pend_r <= pend_r | trig;
      if (cnt_r == CNT_LAST) begin
        start_r <= 1'b0;
        stop_r  <= 1'b1;
        cnt_r   <= '0;
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end else if (stop_r) begin
      if (cnt_r == CNT_LAST) begin
        stop_r <= 1'b0;
        cnt_r  <= '0;
        if (pend_r || trig) begin
          start_r <= 1'b1;
          pend_r  <= 1'b0;
        end
      end else begin
        cnt_r  <= cnt_r + CNT_ONE;
        pend_r <= pend_r | trig;
      end
    end else if (trig) begin
      start_r <= 1'b1;
      cnt_r   <= '0;
    end
  end

  assign start_ext = start_r;
  assign stop_ext  = stop_r;
  assign idle      = ~start_r & ~stop_r & ~pend_r;

endmodule

// File: rtl/recip_freq_meter.sv
// Reciprocal frequency meter: counts whole meas_in periods and the clk_ref
// cycles spanning them over a gate of at least gate_len reference cycles.
module recip_freq_meter
  import freq_meter_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int PULSE_LEN   = DEF_PULSE_LEN,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int HOLDOFF_CYC = DEF_HOLDOFF_CYC
) (
  input  logic             clk_ref,
  input  logic             sys_rstn,
  input  logic             meas_in,
  input  logic             enable,
  input  logic [CNT_W-1:0] gate_len,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] ref_out,
  output logic [CNT_W-1:0] meas_out,
  output logic             overflow,
  output logic             timeout,
  output logic             start_ext,
  output logic             stop_ext,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [31:0]      TO_LAST = 32'(TIMEOUT_CYC - 1);
  localparam logic [31:0]      HO_LAST = 32'(HOLDOFF_CYC - 1);

  state_e           state_r, state_nxt;
  logic [2:0]       sync_r;
  logic [CNT_W-1:0] ref_cnt_r, ref_cnt_nxt;
  logic [CNT_W-1:0] meas_cnt_r, meas_cnt_nxt;
  logic [CNT_W-1:0] gate_len_r, gate_len_nxt;
  logic [CNT_W-1:0] ref_out_r, ref_out_nxt;
  logic [CNT_W-1:0] meas_out_r, meas_out_nxt;
  logic [31:0]      tmr_r, tmr_nxt;
  logic             overflow_r, overflow_nxt;
  logic             timeout_r, timeout_nxt;
  logic             res_valid_r, res_valid_nxt;
  logic             busy_r;
  logic             trig_s;
  logic             seq_idle_s;
  logic             meas_rise_s;
  logic [CNT_W-1:0] ref_inc_s;
  logic [CNT_W-1:0] meas_inc_s;

  assign meas_rise_s = sync_r[1] & ~sync_r[2];
  assign ref_inc_s   = ref_cnt_r + CNT_ONE;
  assign meas_inc_s  = meas_cnt_r + CNT_ONE;

  // Next-state and result datapath for the measurement FSM.
  always_comb begin
    state_nxt     = state_r;
    ref_cnt_nxt   = ref_cnt_r;
    meas_cnt_nxt  = meas_cnt_r;
    gate_len_nxt  = gate_len_r;
    ref_out_nxt   = ref_out_r;
    meas_out_nxt  = meas_out_r;
    tmr_nxt       = tmr_r;
    overflow_nxt  = overflow_r;
    timeout_nxt   = timeout_r;
    res_valid_nxt = res_valid_r;
    trig_s        = 1'b0;
    if (!enable) begin
      state_nxt     = ST_IDLE;
      res_valid_nxt = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nxt    = ST_ARM;
          gate_len_nxt = gate_len;
          tmr_nxt      = 32'd0;
        end
        ST_ARM: begin
          if (meas_rise_s) begin
            ref_cnt_nxt  = '0;
            meas_cnt_nxt = '0;
            tmr_nxt      = 32'd0;
            trig_s       = 1'b1;
            state_nxt    = ST_OPEN;
          end else if (tmr_r == TO_LAST) begin
            timeout_nxt  = 1'b1;
            ref_cnt_nxt  = '0;
            meas_cnt_nxt = '0;
            ref_out_nxt  = '0;
            meas_out_nxt = '0;
            state_nxt    = ST_REPORT;
          end else begin
            tmr_nxt = tmr_r + 32'd1;
          end
        end
        ST_OPEN: begin
          // A saturated counter ends the gate before any further counting.
          if ((ref_cnt_r == CNT_MAX) || (meas_cnt_r == CNT_MAX)) begin
            overflow_nxt = 1'b1;
            ref_out_nxt  = ref_cnt_r;
            meas_out_nxt = meas_cnt_r;
            state_nxt    = ST_REPORT;
          end else begin
            ref_cnt_nxt = ref_inc_s;
            if (meas_rise_s) begin
              meas_cnt_nxt = meas_inc_s;
              tmr_nxt      = 32'd0;
              if (ref_inc_s >= gate_len_r) begin
                ref_out_nxt  = ref_inc_s;
                meas_out_nxt = meas_inc_s;
                trig_s       = 1'b1;
                state_nxt    = ST_REPORT;
              end else begin
                state_nxt = ST_OPEN;
              end
            end else if (tmr_r == TO_LAST) begin
              timeout_nxt  = 1'b1;
              ref_out_nxt  = ref_cnt_r;
              meas_out_nxt = meas_cnt_r;
              state_nxt    = ST_REPORT;
            end else begin
              tmr_nxt = tmr_r + 32'd1;
            end
          end
        end
        ST_REPORT: begin
          if (res_valid_r) begin
            if (res_ready) begin
              res_valid_nxt = 1'b0;
              overflow_nxt  = 1'b0;
              timeout_nxt   = 1'b0;
              tmr_nxt       = 32'd0;
              state_nxt     = ST_HOLDOFF;
            end else begin
              res_valid_nxt = 1'b1;
            end
          end else begin
            res_valid_nxt = seq_idle_s;
          end
        end
        ST_HOLDOFF: begin
          if (tmr_r == HO_LAST) begin
            gate_len_nxt = gate_len;
            tmr_nxt      = 32'd0;
            state_nxt    = ST_ARM;
          end else begin
            tmr_nxt = tmr_r + 32'd1;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // State, counter and result registers.
  always_ff @(posedge clk_ref) begin
    if (!sys_rstn) begin
      state_r     <= ST_IDLE;
      sync_r      <= 3'b000;
      ref_cnt_r   <= '0;
      meas_cnt_r  <= '0;
      gate_len_r  <= '0;
      ref_out_r   <= '0;
      meas_out_r  <= '0;
      tmr_r       <= 32'd0;
      overflow_r  <= 1'b0;
      timeout_r   <= 1'b0;
      res_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt;
      sync_r      <= {sync_r[1:0], meas_in};
      ref_cnt_r   <= ref_cnt_nxt;
      meas_cnt_r  <= meas_cnt_nxt;
      gate_len_r  <= gate_len_nxt;
      ref_out_r   <= ref_out_nxt;
      meas_out_r  <= meas_out_nxt;
      tmr_r       <= tmr_nxt;
      overflow_r  <= overflow_nxt;
      timeout_r   <= timeout_nxt;
      res_valid_r <= res_valid_nxt;
      busy_r      <= (state_nxt != ST_IDLE);
    end
  end

  tdc_pulse_seq #(
    .PULSE_LEN (PULSE_LEN)
  ) u_seq (
    .clk_ref   (clk_ref),
    .sys_rstn  (sys_rstn),
    .trig      (trig_s),
    .abort     (~enable),
    .start_ext (start_ext),
    .stop_ext  (stop_ext),
    .idle      (seq_idle_s)
  );

  assign res_valid = res_valid_r;
  assign ref_out   = ref_out_r;
  assign meas_out  = meas_out_r;
  assign overflow  = overflow_r;
  assign timeout   = timeout_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_recip_freq_meter.sv
// Directed bench for recip_freq_meter: a result table plus hand sequences for
// pulse queuing, back-pressure, abort and reset.
module tb_recip_freq_meter;

  localparam int CNT_W = 8;

  logic             clk_ref = 1'b0;
  logic             sys_rstn;
  logic             meas_in;
  logic             enable;
  logic [CNT_W-1:0] gate_len;
  logic             res_valid;
  logic             res_ready;
  logic [CNT_W-1:0] ref_out;
  logic [CNT_W-1:0] meas_out;
  logic             overflow;
  logic             timeout;
  logic             start_ext;
  logic             stop_ext;
  logic             busy;

  int n_cmp = 0;
  int n_bad = 0;
  int meas_per = 0;

  typedef struct {
    int per;
    int gate;
    int exp_ref;
    int exp_meas;
    int exp_ovf;
    int exp_to;
  } vec_t;

  vec_t vecs[7];

  recip_freq_meter #(
    .CNT_W       (CNT_W),
    .PULSE_LEN   (5),
    .TIMEOUT_CYC (64),
    .HOLDOFF_CYC (16)
  ) dut (
    .clk_ref   (clk_ref),
    .sys_rstn  (sys_rstn),
    .meas_in   (meas_in),
    .enable    (enable),
    .gate_len  (gate_len),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .ref_out   (ref_out),
    .meas_out  (meas_out),
    .overflow  (overflow),
    .timeout   (timeout),
    .start_ext (start_ext),
    .stop_ext  (stop_ext),
    .busy      (busy)
  );

  always #5 clk_ref = ~clk_ref;

  // Square wave of meas_per reference cycles, high for the first half.
  initial begin
    int ph;
    ph = 0;
    meas_in = 1'b0;
    forever begin
      @(posedge clk_ref);
      #2;
      if (meas_per > 0) begin
        ph = (ph + 1) % meas_per;
        meas_in = (ph < meas_per / 2) ? 1'b1 : 1'b0;
      end else begin
        meas_in = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk_ref);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (res_valid !== 1'b1 && cyc < 3000) begin
      tick();
      cyc++;
    end
    chk("res_valid_seen", 32'(res_valid), 32'd1);
  endtask

  task automatic restart(input int per, input int gate);
    enable   = 1'b0;
    meas_per = per;
    gate_len = CNT_W'(gate);
    repeat (4) tick();
    enable = 1'b1;
  endtask

  task automatic take();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  initial begin
    int cyc;
    int starts, stops, both, restart_ok, fell, bad_cyc, vcount;
    logic prev_stop;

    vecs[0] = '{per: 4,  gate: 100, exp_ref: 100, exp_meas: 25, exp_ovf: 0, exp_to: 0};
    vecs[1] = '{per: 10, gate: 50,  exp_ref: 50,  exp_meas: 5,  exp_ovf: 0, exp_to: 0};
    vecs[2] = '{per: 6,  gate: 0,   exp_ref: 6,   exp_meas: 1,  exp_ovf: 0, exp_to: 0};
    vecs[3] = '{per: 8,  gate: 20,  exp_ref: 24,  exp_meas: 3,  exp_ovf: 0, exp_to: 0};
    vecs[4] = '{per: 0,  gate: 10,  exp_ref: 0,   exp_meas: 0,  exp_ovf: 0, exp_to: 1};
    vecs[5] = '{per: 4,  gate: 255, exp_ref: 255, exp_meas: 63, exp_ovf: 1, exp_to: 0};
    vecs[6] = '{per: 5,  gate: 30,  exp_ref: 30,  exp_meas: 6,  exp_ovf: 0, exp_to: 0};

    sys_rstn  = 1'b0;
    enable    = 1'b0;
    res_ready = 1'b0;
    gate_len  = '0;
    repeat (3) tick();
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_ref_out", 32'(ref_out), 32'd0);
    chk("rst_meas_out", 32'(meas_out), 32'd0);
    chk("rst_flags", {28'd0, overflow, timeout, start_ext, stop_ext}, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    sys_rstn = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      restart(vecs[i].per, vecs[i].gate);
      wait_valid(cyc);
      chk($sformatf("v%0d_ref_out", i), 32'(ref_out), 32'(vecs[i].exp_ref));
      chk($sformatf("v%0d_meas_out", i), 32'(meas_out), 32'(vecs[i].exp_meas));
      chk($sformatf("v%0d_overflow", i), 32'(overflow), 32'(vecs[i].exp_ovf));
      chk($sformatf("v%0d_timeout", i), 32'(timeout), 32'(vecs[i].exp_to));
      if (vecs[i].exp_to != 0) begin
        chk("timeout_latency_in_range", 32'((cyc >= 64) && (cyc <= 68)), 32'd1);
      end
      take();
      chk($sformatf("v%0d_valid_dropped", i), 32'(res_valid), 32'd0);
      chk($sformatf("v%0d_flags_cleared", i), {30'd0, overflow, timeout}, 32'd0);
    end

    // Closing trigger lands mid-sequence and must be replayed back to back.
    restart(4, 8);
    starts = 0; stops = 0; both = 0; restart_ok = 0; fell = 0; cyc = 0;
    prev_stop = 1'b0;
    while (res_valid !== 1'b1 && cyc < 3000) begin
      tick();
      cyc++;
      if (start_ext) starts++;
      if (stop_ext) stops++;
      if (start_ext && stop_ext) both++;
      if (prev_stop && !stop_ext && fell == 0) begin
        fell = 1;
        restart_ok = start_ext ? 1 : 0;
      end
      prev_stop = stop_ext;
    end
    chk("pulse_res_valid_seen", 32'(res_valid), 32'd1);
    chk("pulse_start_cycles", 32'(starts), 32'd10);
    chk("pulse_stop_cycles", 32'(stops), 32'd10);
    chk("pulse_never_both", 32'(both), 32'd0);
    chk("pulse_restart_adjacent", 32'(restart_ok), 32'd1);
    chk("pulse_ref_out", 32'(ref_out), 32'd8);
    chk("pulse_meas_out", 32'(meas_out), 32'd2);
    take();

    // Back-pressure: result held for 20 cycles, one transfer, then holdoff.
    restart(4, 40);
    wait_valid(cyc);
    bad_cyc = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (res_valid !== 1'b1 || ref_out !== 8'd40 || meas_out !== 8'd10 ||
          overflow !== 1'b0 || timeout !== 1'b0) bad_cyc++;
    end
    chk("hold_stable_cycles_bad", 32'(bad_cyc), 32'd0);
    take();
    chk("hold_valid_dropped", 32'(res_valid), 32'd0);
    chk("hold_busy_in_holdoff", 32'(busy), 32'd1);
    vcount = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (res_valid) vcount++;
    end
    chk("hold_single_transfer", 32'(vcount), 32'd0);

    // Abort by enable=0 in the middle of an open gate.
    restart(4, 100);
    repeat (12) tick();
    chk("abort_pre_busy", 32'(busy), 32'd1);
    enable = 1'b0;
    tick();
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_pulses", {30'd0, start_ext, stop_ext}, 32'd0);
    chk("abort_valid", 32'(res_valid), 32'd0);

    // Reset in the middle of an open gate with a pulse in flight.
    enable = 1'b1;
    repeat (10) tick();
    sys_rstn = 1'b0;
    tick();
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_pulses", {30'd0, start_ext, stop_ext}, 32'd0);
    chk("rstmid_outputs", {16'd0, ref_out, meas_out}, 32'd0);
    enable = 1'b0;
    sys_rstn = 1'b1;
    vcount = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (res_valid) vcount++;
    end
    chk("rstmid_no_result", 32'(vcount), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/recip_freq_meter.md
RECIP_FREQ_METER -- requirements
Module: recip_freq_meter

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of ref/meas counters and gate_len.
REQ-002 SHALL have parameter PULSE_LEN, default 5, clk_ref cycles per start_ext/stop_ext pulse (>=1).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1_000_000, max clk_ref cycles spent waiting for a meas edge.
REQ-004 SHALL have parameter HOLDOFF_CYC, default 50_000, idle cycles between measurements.
REQ-005 SHALL have ports: clk_ref in 1 sole clock; sys_rstn in 1 reset, synchronous, active-low.
REQ-006 SHALL have ports: meas_in in 1 async signal under test; enable in 1 run; gate_len in CNT_W minimum gate in clk_ref cycles.
REQ-007 SHALL have ports: res_valid out 1; res_ready in 1; ref_out out CNT_W; meas_out out CNT_W; overflow out 1; timeout out 1.
REQ-008 SHALL have ports: start_ext out 1; stop_ext out 1 (TDC pulses); busy out 1 (state != IDLE).

Function
REQ-009 meas_in SHALL pass a 3-flop synchroniser; meas_rise = stage2 & ~stage3, one cycle per rising edge; meas_in frequency < clk_ref/2 is the supported range.
REQ-010 FSM states SHALL be IDLE, ARM, OPEN, REPORT, HOLDOFF.
REQ-011 IDLE->ARM when enable=1; gate_len sampled into gate_len_q on that transition.
REQ-012 ARM: on meas_rise, ref_cnt<=0, meas_cnt<=0, trigger pulse sequence, ->OPEN; after TIMEOUT_CYC cycles with no meas_rise, timeout<=1, counts 0, ->REPORT.
REQ-013 OPEN: ref_cnt increments every cycle; meas_cnt increments on each meas_rise.
REQ-014 OPEN->REPORT on the first meas_rise at which incremented ref_cnt >= gate_len_q; that edge is counted; pulse sequence triggered; ref_out/meas_out latched same cycle.
REQ-015 Result SHALL be ref_out = whole meas periods x period in clk_ref cycles, meas_out = number of whole meas periods (reciprocal counting, +/-1 ref cycle error).
REQ-016 Either counter at all-ones SHALL saturate, set overflow=1, and force ->REPORT next cycle with saturated values.
REQ-017 OPEN with no meas_rise for TIMEOUT_CYC cycles SHALL set timeout=1 and ->REPORT with current counts.
REQ-018 REPORT: res_valid asserts once pulse sequencer idle; ref_out, meas_out, overflow, timeout stable while res_valid=1.
REQ-019 Handshake: transfer on res_valid & res_ready; next cycle res_valid=0, flags cleared, ->HOLDOFF; res_valid never drops without transfer except enable=0 or reset.
REQ-020 HOLDOFF: HOLDOFF_CYC cycles, then ->ARM if enable=1 (resampling gate_len) else ->IDLE.
REQ-021 Pulse sequence: start_ext=1 for PULSE_LEN cycles starting cycle after trigger, then stop_ext=1 for PULSE_LEN cycles; never both high.
REQ-022 Trigger while sequence active SHALL be held pending (depth 1), sequence restarts the cycle after current stop pulse ends.
REQ-023 enable=0 in any state SHALL abort to IDLE next cycle: res_valid=0, start_ext/stop_ext=0, pending cleared, outputs retain last values.
REQ-024 gate_len_q=0 SHALL close the gate at the second meas edge (one period measured).

Reset
REQ-025 On sys_rstn=0 at a clk_ref edge: state=IDLE, all counters, synchroniser and pending flag 0, ref_out=meas_out=0, res_valid=overflow=timeout=start_ext=stop_ext=busy=0.
REQ-026 Reset mid-measurement or mid-pulse SHALL take effect on the same edge, no result emitted.

Structure
REQ-027 Package freq_meter_pkg SHALL hold the state enum and default parameter constants.
REQ-028 Pulse sequencer SHALL be sub-module tdc_pulse_seq (inputs trig, abort; outputs start_ext, stop_ext, idle).

Verification
REQ-029 meas_in period 4 clk_ref, gate_len=100 -> ref_out=100, meas_out=25, overflow=0, timeout=0.
REQ-030 meas_in static, TIMEOUT_CYC=64 -> res_valid after ~64 ARM cycles, timeout=1, ref_out=meas_out=0.
REQ-031 PULSE_LEN=5, period 4, gate_len=8 -> closing trigger pending, second start_ext begins cycle after first stop_ext ends; res_valid waits for idle.
REQ-032 res_ready=0 for 20 cycles after res_valid -> outputs stable 20 cycles, single transfer, then HOLDOFF.
REQ-033 CNT_W=8, period 4, gate_len=255 -> ref saturates 255, overflow=1, res_valid asserted.
REQ-034 enable=0 or sys_rstn=0 mid-OPEN -> IDLE next cycle, no res_valid, pulses forced 0.
